// File: rtl/alu_issue_unit.sv
// Front end of the ALU: decode, register-file operand read, valid/ready issue, result writeback.
// Optional build macro ALU_ILLEGAL_TRAP_EN drives illegal_instr on undecodable instructions.
module alu_issue_unit #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ID_W           = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       ir,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [ID_W-1:0]   instr_ID,
  output logic [DATA_W-1:0] op_rs,
  output logic [DATA_W-1:0] op_rt,
  input  logic              result_valid,
  input  logic [DATA_W-1:0] result,
  output logic              busy,
  output logic              illegal_instr,
  output logic              timeout,
  input  logic [4:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  typedef enum logic [1:0] {StIdle, StDecode, StIssue, StWait} state_e;
  typedef enum logic [1:0] {SrcReg, SrcSext, SrcZext, SrcShamt} src_e;

  state_e            state_q, state_d;
  logic [31:0]       ir_q, ir_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] rs_q, rs_d, rt_q, rt_d;
  logic [4:0]        dest_q, dest_d;
  logic              wb_en_q, wb_en_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] regs_q [32];
  logic              we;

  logic [5:0]  f_op, f_funct;
  logic [4:0]  f_rs, f_rt, f_rd;
  logic [15:0] f_imm;

  assign f_op    = ir_q[31:26];
  assign f_rs    = ir_q[25:21];
  assign f_rt    = ir_q[20:16];
  assign f_rd    = ir_q[15:11];
  assign f_imm   = ir_q[15:0];
  assign f_funct = ir_q[5:0];

  logic              dec_legal, dec_use_rd, dec_wb;
  logic [4:0]        dec_id;
  src_e              dec_src;
  logic [DATA_W-1:0] rs_val, rt_reg, rt_val;

  always_comb begin
    dec_legal  = 1'b1;
    dec_id     = 5'd0;
    dec_src    = SrcReg;
    dec_use_rd = 1'b1;
    dec_wb     = 1'b1;
    case (f_op)
      6'd0: begin
        if (f_funct <= 6'd3) dec_id = 5'(f_funct) + 5'd1;
        else                 dec_legal = 1'b0;
      end
      6'd1:  begin dec_id = 5'd5;  dec_src = SrcSext; dec_use_rd = 1'b0; end
      6'd2:  begin dec_id = 5'd6;  dec_src = SrcSext; dec_use_rd = 1'b0; end
      6'd3:  begin dec_id = 5'd7;  dec_legal = (f_funct == 6'd0); end
      6'd4:  begin dec_id = 5'd8;  dec_legal = (f_funct == 6'd0); end
      6'd5:  begin dec_id = 5'd9;  dec_src = SrcZext; dec_use_rd = 1'b0; end
      6'd6:  begin dec_id = 5'd10; dec_src = SrcZext; dec_use_rd = 1'b0; end
      6'd7: begin
        dec_src    = SrcShamt;
        dec_use_rd = 1'b0;
        if (f_funct == 6'd0)      dec_id = 5'd11;
        else if (f_funct == 6'd1) dec_id = 5'd12;
        else                      dec_legal = 1'b0;
      end
      6'd19: begin dec_id = 5'd24; dec_legal = (f_funct == 6'd0); end
      6'd20: begin dec_id = 5'd25; dec_src = SrcSext; dec_use_rd = 1'b0; end
      6'd21: begin dec_id = 5'd26; dec_wb = 1'b0; dec_legal = (f_funct == 6'd0); end
      6'd22: begin dec_id = 5'd27; dec_wb = 1'b0; dec_legal = (f_funct == 6'd0); end
      6'd23: begin dec_id = 5'd28; dec_legal = (f_funct == 6'd0); end
      default: dec_legal = 1'b0;
    endcase
  end

  assign rs_val = (f_rs == 5'd0) ? '0 : regs_q[f_rs];
  assign rt_reg = (f_rt == 5'd0) ? '0 : regs_q[f_rt];

  always_comb begin
    rt_val = rt_reg;
    case (dec_src)
      SrcSext:  rt_val = {{(DATA_W-16){f_imm[15]}}, f_imm};
      SrcZext:  rt_val = DATA_W'(f_imm);
      SrcShamt: rt_val = DATA_W'(f_imm[4:0]);
      default:  rt_val = rt_reg;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    id_d        = id_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    dest_d      = dest_q;
    wb_en_d     = wb_en_q;
    cnt_d       = cnt_q;
    we          = 1'b0;
    timeout     = 1'b0;
    instr_ready = (state_q == StIdle);
    issue_valid = (state_q == StIssue);
    busy        = (state_q != StIdle);
    case (state_q)
      StIdle: begin
        if (instr_valid) begin
          ir_d    = ir;
          state_d = StDecode;
        end
      end
      StDecode: begin
        if (dec_legal) begin
          id_d    = ID_W'(dec_id);
          rs_d    = rs_val;
          rt_d    = rt_val;
          dest_d  = dec_use_rd ? f_rd : f_rt;
          wb_en_d = dec_wb;
          state_d = StIssue;
        end else begin
          state_d = StIdle;
        end
      end
      StIssue: begin
        if (issue_ready) begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (result_valid) begin
          we      = wb_en_q && (dest_q != 5'd0);
          state_d = StIdle;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TIMEOUT_CYCLES - 32'd1) begin
          timeout = 1'b1;
          state_d = StIdle;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + 32'd1;
        end
        // Leaving WAIT returns the issue outputs to their idle value.
        if (state_d == StIdle) begin
          id_d = '0;
          rs_d = '0;
          rt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef ALU_ILLEGAL_TRAP_EN
  assign illegal_instr = (state_q == StDecode) && !dec_legal;
`else
  assign illegal_instr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ir_q    <= '0;
      id_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      dest_q  <= '0;
      wb_en_q <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      id_q    <= id_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      dest_q  <= dest_d;
      wb_en_q <= wb_en_d;
      cnt_q   <= cnt_d;
      if (we) regs_q[dest_q] <= result;
    end
  end

  assign instr_ID = id_q;
  assign op_rs    = rs_q;
  assign op_rt    = rt_q;
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: directed instructions, issue scoreboard checked by a separate monitor.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [31:0] ir = '0;
  logic        issue_valid;
  logic        issue_ready = 1'b1;
  logic [31:0] instr_ID;
  logic [31:0] op_rs, op_rt;
  logic        result_valid = 1'b0;
  logic [31:0] result = '0;
  logic        busy, illegal_instr, timeout;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

`ifdef ALU_ILLEGAL_TRAP_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif

  alu_issue_unit dut (
    .clk          (clk),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .ir           (ir),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .instr_ID     (instr_ID),
    .op_rs        (op_rs),
    .op_rt        (op_rt),
    .result_valid (result_valid),
    .result       (result),
    .busy         (busy),
    .illegal_instr(illegal_instr),
    .timeout      (timeout),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] id;
    logic [31:0] rs;
    logic [31:0] rt;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every issue handshake pops one expected entry.
  always @(negedge clk) begin
    if (!reset && issue_valid && issue_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue actual_id=%h required=none", instr_ID);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("issue_id", instr_ID, e.id);
        check("issue_rs", op_rs, e.rs);
        check("issue_rt", op_rt, e.rt);
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 10; i++) begin
      if (instr_ready) break;
      @(posedge clk); #1;
    end
    check("accept_ready", {31'd0, instr_ready}, 32'd1);
  endtask

  task automatic dbg_check(input string name, input logic [4:0] a, input logic [31:0] req);
    dbg_addr = a;
    #1;
    check(name, dbg_data, req);
  endtask

  task automatic exec(input logic [31:0] w, input logic [31:0] id, input logic [31:0] rs,
                      input logic [31:0] rt, input int hold, input bit give,
                      input logic [31:0] res);
    exp_t e;
    bit   ok;
    e.id = id; e.rs = rs; e.rt = rt;
    exp_q.push_back(e);
    wait_ready();
    ir = w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        check("hold_valid", {31'd0, issue_valid}, 32'd1);
        check("hold_id", instr_ID, id);
        check("hold_rs", op_rs, rs);
        check("hold_rt", op_rt, rt);
        @(posedge clk); #1;
      end
      issue_ready = 1'b1;
    end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (issue_valid && issue_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("issue_handshake", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    if (give) begin
      result_valid = 1'b1;
      result = res;
      @(posedge clk); #1;
      result_valid = 1'b0;
    end
  endtask

  task automatic exec_illegal(input logic [31:0] w);
    wait_ready();
    ir = w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("illegal_pulse", {31'd0, illegal_instr}, {31'd0, EXP_ILL});
    check("illegal_no_issue", {31'd0, issue_valid}, 32'd0);
    @(posedge clk); #1;
    check("illegal_pulse_end", {31'd0, illegal_instr}, 32'd0);
    check("illegal_idle", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int k;
    // Reset
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
    check("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_instr_id", instr_ID, 32'd0);
    check("rst_op_rs", op_rs, 32'd0);
    check("rst_op_rt", op_rt, 32'd0);
    for (int a = 0; a < 32; a++) dbg_check("rst_reg", 5'(a), 32'd0);

    // addi r1,r0,100
    exec(32'h04010064, 32'd5, 32'd0, 32'd100, 0, 1'b1, 32'd100);
    dbg_check("addi_r1", 5'd1, 32'd100);
    // addi r2,r0,-1 ; andi r4,r2,0xFFFF
    exec(32'h0402FFFF, 32'd5, 32'd0, 32'hFFFFFFFF, 0, 1'b1, 32'hFFFFFFFF);
    dbg_check("addi_r2", 5'd2, 32'hFFFFFFFF);
    exec(32'h1444FFFF, 32'd9, 32'hFFFFFFFF, 32'h0000FFFF, 0, 1'b1, 32'h0000FFFF);
    dbg_check("andi_r4", 5'd4, 32'h0000FFFF);
    // add r3,r1,r2 with ALU stalling for 5 cycles
    issue_ready = 1'b0;
    exec(32'h00221800, 32'd1, 32'd100, 32'hFFFFFFFF, 5, 1'b1, 32'd99);
    dbg_check("add_r3", 5'd3, 32'd99);
    // madd: no writeback
    exec(32'h54220000, 32'd26, 32'd100, 32'hFFFFFFFF, 0, 1'b1, 32'd7);
    dbg_check("madd_r0", 5'd0, 32'd0);
    dbg_check("madd_r1", 5'd1, 32'd100);
    dbg_check("madd_r2", 5'd2, 32'hFFFFFFFF);
    // addi r0,r0,5: r0 stays zero
    exec(32'h04000005, 32'd5, 32'd0, 32'd5, 0, 1'b1, 32'd5);
    dbg_check("r0_zero", 5'd0, 32'd0);
    // Stray result in IDLE
    result_valid = 1'b1;
    result = 32'hDEAD;
    repeat (2) @(posedge clk);
    #1;
    result_valid = 1'b0;
    check("stray_busy", {31'd0, busy}, 32'd0);
    dbg_check("stray_r1", 5'd1, 32'd100);
    dbg_check("stray_r3", 5'd3, 32'd99);

    // Illegal instructions
    exec_illegal(32'hFC000000);
    exec_illegal(32'h00000004);

    // Timeout: add r5,r1,r2 with no result
    exec(32'h00222800, 32'd1, 32'd100, 32'hFFFFFFFF, 0, 1'b0, 32'd0);
    k = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (timeout) begin
        k = i;
        break;
      end
    end
    check("timeout_cycles", k, 32'd64);
    @(posedge clk); #1;
    check("timeout_idle", {31'd0, busy}, 32'd0);
    check("timeout_id_clear", instr_ID, 32'd0);
    dbg_check("timeout_no_write", 5'd5, 32'd0);

    // Reset during ISSUE with a coincident result
    issue_ready = 1'b0;
    wait_ready();
    ir = 32'h0406004D;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_reset_issue", {31'd0, issue_valid}, 32'd1);
    reset = 1'b1;
    result_valid = 1'b1;
    result = 32'd77;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    result_valid = 1'b0;
    issue_ready = 1'b1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_issue", {31'd0, issue_valid}, 32'd0);
    check("mid_rst_id", instr_ID, 32'd0);
    dbg_check("mid_rst_r6", 5'd6, 32'd0);
    dbg_check("mid_rst_r1", 5'd1, 32'd0);

    // Recovery plus shift-amount immediate form
    exec(32'h04010064, 32'd5, 32'd0, 32'd100, 0, 1'b1, 32'd100);
    dbg_check("recover_r1", 5'd1, 32'd100);
    exec(32'h1C220001, 32'd12, 32'd100, 32'd1, 0, 1'b1, 32'h55);
    dbg_check("shamt_r2", 5'd2, 32'h55);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
